mul_unit: RTL
=============

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  EX stage presents a multiply op.
REQ-005 in_ready  out  1  unit can accept an op this cycle.
REQ-006 op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 rs1  in  32  multiplicand operand.
REQ-008 rs2  in  32  multiplier operand.
REQ-009 flush  in  1  pipeline kill; abort any op in flight.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  MEM/WB side takes result.
REQ-012 result  out  32  selected half of product.
REQ-013 busy  out  1  op accepted and not yet retired.

Function
REQ-014 The unit SHALL be an iterative shift-add multiplier with FSM states IDLE, CALC, DONE.
REQ-015 The unit SHALL drive in_ready = (state==IDLE) && !flush; busy = (state!=IDLE); out_valid = (state==DONE).
REQ-016 An op SHALL be accepted on a rising edge with in_valid && in_ready; acceptance latches op, converts operands to magnitudes per signedness (MUL/MULHU both unsigned, MULH both signed, MULHSU rs1 signed/rs2 unsigned), records sign flag = XOR of operand signs, clears accumulator and iteration counter, and moves to CALC.
REQ-017 Each CALC edge SHALL add the multiplicand to the upper accumulator half when the multiplier LSB is 1, using a 33-bit sum (carry kept), then shift {carry, acc_hi, multiplier} right by one.
REQ-018 CALC SHALL take exactly 32 edges regardless of operand values (zero operands included); 5-bit counter, on count 31 transition to DONE.
REQ-019 Latency SHALL be fixed: out_valid first high after the 32nd edge following the accepting edge.
REQ-020 In DONE the 64-bit product SHALL be two's-complement-negated when the sign flag is set; result = low 32 bits for MUL, high 32 bits otherwise.
REQ-021 result SHALL hold stable while out_valid && !out_ready.
REQ-022 On an edge with out_valid && out_ready the unit SHALL return to IDLE; no new op is accepted in that same edge (back-to-back issue spacing minimum 34 cycles).
REQ-023 flush SHALL send the FSM to IDLE on the next edge from any state, discarding the op; flush wins over in_valid and over out_ready in the same cycle.
REQ-024 in_valid while busy SHALL be ignored; operand changes after acceptance SHALL not affect the result.

Reset
REQ-025 While rst_n is low at a rising edge: state IDLE, counter 0, accumulator and multiplier 0, sign flag 0, latched op 00.
REQ-026 After the reset edge: in_ready 1, out_valid 0, busy 0, result 0x00000000.
REQ-027 Reset mid-CALC or mid-DONE SHALL discard the op with no out_valid pulse.

Structure
REQ-028 Op encodings, FSM state encoding, and XLEN SHALL live in shared package mul_pkg, reused by the decoder and EX stage.
REQ-029 The 33-bit add SHALL be a combinational sub-module mul_add33 (a[31:0], b[31:0] -> sum[31:0], cout), instantiated once.

Verification
REQ-030 MUL rs1=7, rs2=6, out_ready=1 -> out_valid exactly 32 edges after accept, result 0x0000002A, then in_ready 1 next cycle.
REQ-031 MULH rs1=0x80000000, rs2=0x80000000 -> result 0x40000000; MUL same operands -> 0x00000000.
REQ-032 MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE.
REQ-033 MUL rs1=0x12345678, rs2=0 -> still 32-cycle latency, result 0; out_ready held 0 for 5 cycles -> result/out_valid stable, retire on 6th.
REQ-034 Flush at CALC iteration 10, then new MUL 3*5 accepted -> no stale result, result 0x0000000F; flush asserted with in_valid in IDLE -> op not accepted.
REQ-035 rst_n low for one edge during CALC -> out_valid never pulses, in_ready 1 next cycle, result 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared multiply-unit definitions: operand width, op encodings, FSM state
// encoding and small operand/result helpers. The decoder and EX stage import
// this package as well, so every consumer sees the same op encoding.
package mul_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned PLEN  = 2 * XLEN;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } mul_state_e;

   // rs1 is treated as signed for MULH and MULHSU
   function automatic logic rs1_is_signed(mul_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU);
   endfunction

   // rs2 is treated as signed only for MULH
   function automatic logic rs2_is_signed(mul_op_e op);
      return (op == OP_MULH);
   endfunction

   // Magnitude of an operand; the most negative value maps onto itself,
   // which is still the correct unsigned magnitude 2^(XLEN-1).
   function automatic logic [XLEN-1:0] magnitude(logic [XLEN-1:0] x, logic is_signed);
      return (is_signed && x[XLEN-1]) ? XLEN'(-x) : x;
   endfunction

   // MUL returns the low half of the product, all other ops the high half
   function automatic logic [XLEN-1:0] select_half(mul_op_e op, logic [PLEN-1:0] p);
      return (op == OP_MUL) ? p[XLEN-1:0] : p[PLEN-1:XLEN];
   endfunction

endpackage

// File: rtl/mul_add33.sv
// Combinational 32+32 adder with carry out (33-bit sum) used by the
// shift-add multiplier.
//   a, b : addends
//   sum  : low 32 bits of a+b
//   cout : carry out of bit 31
module mul_add33
   import mul_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] sum,
   output logic            cout
);

   assign {cout, sum} = (XLEN + 1)'(a) + (XLEN + 1)'(b);

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for the M extension (MUL/MULH/MULHSU/MULHU).
// Fixed latency: 32 CALC edges after the accepting edge, then the result is
// held in DONE until the consumer takes it.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : op handshake from EX
//   op, rs1, rs2        : op select and operands
//   flush               : pipeline kill, aborts any op in flight
//   out_valid/out_ready : result handshake to MEM/WB
//   result              : selected half of the product
//   busy                : op accepted and not yet retired
module mul_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   import mul_pkg::*;

   localparam int unsigned PW = 2 * XLEN;

   mul_state_e         state_q;
   mul_op_e            op_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [XLEN-1:0]    mcand_q;
   logic [XLEN-1:0]    mplier_q;
   logic [XLEN-1:0]    acc_hi_q;
   logic               neg_q;
   logic [XLEN-1:0]    result_q;

   logic [XLEN-1:0]    addend;
   logic [XLEN-1:0]    sum;
   logic               cout;
   logic [XLEN-1:0]    acc_hi_nx;
   logic [XLEN-1:0]    mplier_nx;
   logic [PW-1:0]      prod_nx;
   logic [PW-1:0]      prod_fin;
   logic [XLEN-1:0]    res_nx;
   mul_op_e            op_in;
   logic               s1;
   logic               s2;

   // Multiplicand is added only when the current multiplier LSB is set
   assign addend = mplier_q[0] ? mcand_q : '0;

   mul_add33 u_add (
      .a    (acc_hi_q),
      .b    (addend),
      .sum  (sum),
      .cout (cout)
   );

   // Shift {carry, sum, multiplier} right by one; on the last iteration
   // this is the full unsigned product, sign-corrected before latching.
   always_comb begin
      acc_hi_nx = {cout, sum[XLEN-1:1]};
      mplier_nx = {sum[0], mplier_q[XLEN-1:1]};
      prod_nx   = {acc_hi_nx, mplier_nx};
      prod_fin  = neg_q ? PW'(-prod_nx) : prod_nx;
      res_nx    = select_half(op_q, prod_fin);
   end

   // Operand signedness for the op presented this cycle
   always_comb begin
      op_in = mul_op_e'(op);
      s1    = rs1_is_signed(op_in) && rs1[XLEN-1];
      s2    = rs2_is_signed(op_in) && rs2[XLEN-1];
   end

   // Control FSM and datapath registers; flush outranks every handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_hi_q <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else if (flush) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q     <= op_in;
                  mcand_q  <= magnitude(rs1, rs1_is_signed(op_in));
                  mplier_q <= magnitude(rs2, rs2_is_signed(op_in));
                  neg_q    <= s1 ^ s2;
                  acc_hi_q <= '0;
                  cnt_q    <= '0;
                  state_q  <= ST_CALC;
               end
            end
            ST_CALC: begin
               acc_hi_q <= acc_hi_nx;
               mplier_q <= mplier_nx;
               cnt_q    <= CNT_W'(cnt_q + CNT_W'(1));
               if (cnt_q == CNT_W'(XLEN - 1)) begin
                  result_q <= res_nx;
                  state_q  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE) && !flush;
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;

endmodule
